// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO widths, Gray/binary helpers and reset values
package fifo_pkg;
  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic EMPTY_RST = 1'b1;
  localparam logic AEMPTY_RST = 1'b1;
  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    for (int i = 0; i < PTR_WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: XOR-prefix Gray-to-binary converter (gray in, bin out, W bits)
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end
endmodule

// File: rtl/fifo_rd.sv
// fifo_rd: async-FIFO read-side pointer/flags (rclk, rrst_n, rinc, gray_wr_ptr in; r_addr, gray_rd_ptr, rempty, raempty, rd_level out)
module fifo_rd #(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int AEMPTY_TH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rd_level
);
  import fifo_pkg::EMPTY_RST;
  import fifo_pkg::AEMPTY_RST;
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH + 1)'(AEMPTY_TH);
  logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_next, gray_next, wr_bin, diff;
  logic r_en;
  fifo_gray2bin #(.W(ADDR_WIDTH + 1)) u_g2b (.gray(gray_wr_ptr), .bin(wr_bin));
  assign r_en = rinc & ~rempty;
  assign rd_ptr_next = rd_ptr + {{ADDR_WIDTH{1'b0}}, r_en};
  assign gray_next = rd_ptr_next ^ (rd_ptr_next >> 1);
  assign diff = wr_bin - rd_ptr_next;
  assign r_addr = rd_ptr[ADDR_WIDTH-1:0];
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rd_ptr <= '0;
      gray_rd_ptr <= '0;
      rempty <= EMPTY_RST;
      raempty <= AEMPTY_RST;
      rd_level <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      gray_rd_ptr <= gray_next;
      rempty <= gray_next == gray_wr_ptr;
      raempty <= diff <= AE_TH;
      rd_level <= diff;
    end
endmodule

// File: tb/tb_fifo_rd.sv
// tb_fifo_rd: randomized self-checking bench for fifo_rd against an occupancy-count model
module tb_fifo_rd;
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  logic rinc = 1'b0;
  logic [3:0] gray_wr_ptr = '0;
  logic [2:0] r_addr;
  logic [3:0] gray_rd_ptr;
  logic rempty, raempty;
  logic [3:0] rd_level;
  int n_chk = 0;
  int n_fail = 0;
  int wr = 0;
  int rd = 0;
  int exp_level = 0;
  logic exp_empty = 1'b1;
  logic exp_aempty = 1'b1;
  logic [3:0] prev_gray = '0;
  fifo_rd dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .gray_wr_ptr(gray_wr_ptr),
    .r_addr(r_addr), .gray_rd_ptr(gray_rd_ptr), .rempty(rempty),
    .raempty(raempty), .rd_level(rd_level)
  );
  always #5 rclk = ~rclk;
  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset(input int w);
    #2;
    rrst_n = 1'b0;
    rinc = 1'b0;
    wr = w & 15;
    gray_wr_ptr = gray(4'(wr));
    #1;
    check("rst_empty", rempty, 1);
    check("rst_aempty", raempty, 1);
    check("rst_addr", r_addr, 0);
    check("rst_gray", gray_rd_ptr, 0);
    check("rst_level", rd_level, 0);
    rd = 0;
    exp_empty = 1'b1;
    exp_level = 0;
    exp_aempty = 1'b1;
    prev_gray = '0;
    repeat (2) @(posedge rclk);
    #1;
    check("rst_hold_empty", rempty, 1);
    check("rst_hold_addr", r_addr, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask
  task automatic step(input logic ri, input int w);
    int rn;
    rinc = ri;
    wr = w & 15;
    gray_wr_ptr = gray(4'(wr));
    rn = (ri && !exp_empty) ? ((rd + 1) & 15) : rd;
    exp_empty = (rn == wr);
    exp_level = (wr - rn) & 15;
    exp_aempty = exp_level <= 2;
    rd = rn;
    @(posedge rclk);
    #1;
    check("r_addr", r_addr, rd & 7);
    check("gray_rd_ptr", gray_rd_ptr, gray(4'(rd)));
    check("rempty", rempty, exp_empty);
    check("raempty", raempty, exp_aempty);
    check("rd_level", rd_level, exp_level);
    check("gray_one_bit", $countones(gray_rd_ptr ^ prev_gray) <= 1, 1);
    prev_gray = gray_rd_ptr;
    @(negedge rclk);
  endtask
  initial begin
    @(negedge rclk);
    do_reset(4);
    step(0, 4);
    do_reset(0);
    repeat (5) step(1, 0);
    do_reset(3);
    repeat (6) step(1, 3);
    for (int i = 0; i < 20; i++) step(1, wr + 1);
    do_reset(8);
    step(0, 8);
    repeat (9) step(1, 8);
    do_reset(8);
    step(0, 8);
    repeat (5) step(1, 8);
    check("pre_reset_addr", r_addr, 5);
    do_reset(8);
    for (int i = 0; i < 400; i++) begin
      int w;
      w = wr;
      if (((wr - rd) & 15) < 8 && $urandom_range(0, 1) == 1) w = wr + 1;
      step(1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 8));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
